// File: rtl/mqst_pkg.sv
// Shared definitions for the Manchester receive path: timing defaults, line codes, FSM states.
package mqst_pkg;

    localparam int unsigned MQST_CLK_PER_BIT = 16;
    localparam int unsigned MQST_TOL         = 2;

    localparam logic [1:0] MQST_ZERO = 2'b10;
    localparam logic [1:0] MQST_ONE  = 2'b01;

    typedef enum logic [1:0] {
        HUNT,
        START,
        DATA
    } mqst_state_e;

endpackage

// File: rtl/mqst_decoder_if.sv
// Line input and decoded-bit outputs of the Manchester decoder.
interface mqst_decoder_if;

    logic Mqst_BitIn;
    logic Bit_in;
    logic Bit_in_valid;
    logic link_active;
    logic frame_end;
    logic code_err;

    modport master (
        output Mqst_BitIn,
        input  Bit_in,
        input  Bit_in_valid,
        input  link_active,
        input  frame_end,
        input  code_err
    );

    modport slave (
        input  Mqst_BitIn,
        output Bit_in,
        output Bit_in_valid,
        output link_active,
        output frame_end,
        output code_err
    );

endinterface

// File: rtl/mqst_line_sync.sv
// Two-flop synchroniser for the asynchronous line plus a delayed copy for edge detection.
module mqst_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_s,
    output logic rise,
    output logic fall
);

    // [0] first sync stage, [1] synced line, [2] previous synced value
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], line_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign line_s = sync_q[1];
    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/mqst_decoder.sv
// Manchester receive decoder: oversampled bit recovery with mid-bit resync, start-bit
// stripping, end-of-frame and code-violation detection.
module mqst_decoder
    import mqst_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = MQST_CLK_PER_BIT,
    parameter int unsigned TOL         = MQST_TOL
) (
    input  logic          clk,
    input  logic          rst_n,
    mqst_decoder_if.slave bus
);

    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam int unsigned H  = CLK_PER_BIT / 2;
    localparam int unsigned Q  = CLK_PER_BIT / 4;

    localparam logic [CW-1:0] CntMax    = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CntS1     = CW'(Q);
    localparam logic [CW-1:0] CntS2     = CW'(H + Q);
    localparam logic [CW-1:0] CntEval   = CW'(H + Q + 1);
    localparam logic [CW-1:0] CntWinLo  = CW'(H - TOL);
    localparam logic [CW-1:0] CntWinHi  = CW'(H + TOL);
    localparam logic [CW-1:0] CntResync = CW'(H + 1);

    mqst_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1_q, s1_d, s2_q, s2_d;
    logic          bit_q, bit_d, valid_q, valid_d;
    logic          fend_q, fend_d, cerr_q, cerr_d;
    logic          line_s, rise, fall;
    logic [1:0]    pair;

    mqst_line_sync u_line_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (bus.Mqst_BitIn),
        .line_s  (line_s),
        .rise    (rise),
        .fall    (fall)
    );

    assign pair = {s1_q, s2_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        bit_d   = bit_q;
        valid_d = 1'b0;
        fend_d  = 1'b0;
        cerr_d  = 1'b0;

        if (state_q == HUNT) begin
            cnt_d = '0;
            // The detection cycle itself counts as sample 0.
            if (rise) begin
                cnt_d   = CW'(1);
                state_d = START;
            end
        end else begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
            if ((rise || fall) && (cnt_q >= CntWinLo) && (cnt_q <= CntWinHi)) begin
                cnt_d = CntResync;
            end
            if (cnt_q == CntS1) s1_d = line_s;
            if (cnt_q == CntS2) s2_d = line_s;

            if (cnt_q == CntEval) begin
                if (state_q == START) begin
                    case (pair)
                        MQST_ZERO: state_d = DATA;
                        2'b00:     state_d = HUNT;
                        default: begin
                            cerr_d  = 1'b1;
                            state_d = HUNT;
                        end
                    endcase
                end else begin
                    case (pair)
                        MQST_ZERO: begin
                            bit_d   = 1'b0;
                            valid_d = 1'b1;
                        end
                        MQST_ONE: begin
                            bit_d   = 1'b1;
                            valid_d = 1'b1;
                        end
                        2'b00: begin
                            fend_d  = 1'b1;
                            state_d = HUNT;
                        end
                        default: begin
                            cerr_d  = 1'b1;
                            state_d = HUNT;
                        end
                    endcase
                end
                if (state_d == HUNT) cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            fend_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            fend_q  <= fend_d;
            cerr_q  <= cerr_d;
        end
    end

    assign bus.Bit_in       = bit_q;
    assign bus.Bit_in_valid = valid_q;
    assign bus.frame_end    = fend_q;
    assign bus.code_err     = cerr_q;
    assign bus.link_active  = (state_q != HUNT);

endmodule

// File: tb/tb_mqst_decoder.sv
// Scoreboard bench for mqst_decoder: directed Manchester frames with hand-computed event times.
module tb_mqst_decoder;

    localparam logic [2:0] KVal = 3'b001;
    localparam logic [2:0] KEnd = 3'b010;
    localparam logic [2:0] KErr = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic       b;
        int         cyc;
        string      name;
    } exp_t;

    logic clk;
    logic rst_n;
    logic line;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0;
    exp_t sb_q[$];

    mqst_decoder_if bus ();
    assign bus.Mqst_BitIn = line;

    mqst_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic expect_ev(input logic [2:0] k, input logic b, input int c, input string n);
        exp_t e;
        e.kind = k;
        e.b    = b;
        e.cyc  = c;
        e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", n, act, req, cyc);
        end
    endtask

    // Called at a negedge: hold the line at lvl for n posedges.
    task automatic seg(input logic lvl, input int n);
        line = lvl;
        repeat (n) @(negedge clk);
    endtask

    // j shifts the mid-bit edge (and the rest of the timeline) by j clocks.
    task automatic man_bit(input logic b, input int j);
        if (b) begin
            seg(1'b0, 8 + j);
            seg(1'b1, 8);
        end else begin
            seg(1'b1, 8 + j);
            seg(1'b0, 8);
        end
    endtask

    task automatic start_bit();
        seg(1'b1, 8);
        seg(1'b0, 8);
    endtask

    // Monitor: every output pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin
        logic [2:0] k;
        exp_t e;
        if (rst_n) begin
            k = {bus.code_err, bus.frame_end, bus.Bit_in_valid};
            if (k != 3'b000) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got kind=%b bit=%b at cyc %0d, expected none",
                             k, bus.Bit_in, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (k != e.kind || cyc != e.cyc || (e.kind == KVal && bus.Bit_in != e.b)) begin
                        failures++;
                        $display("FAIL %s: got kind=%b bit=%b cyc=%0d, expected kind=%b bit=%b cyc=%0d",
                                 e.name, k, bus.Bit_in, cyc, e.kind, e.b, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        line  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bit_in", 32'(bus.Bit_in), 0);
        chk("rst_valid", 32'(bus.Bit_in_valid), 0);
        chk("rst_link_active", 32'(bus.link_active), 0);
        chk("rst_frame_end", 32'(bus.frame_end), 0);
        chk("rst_code_err", 32'(bus.code_err), 0);
        rst_n = 1'b1;
        seg(1'b0, 10);

        // Ideal frame 1,0,1,1.
        t0 = cyc + 1;
        expect_ev(KVal, 1'b1, t0 + 31, "ideal_b0");
        expect_ev(KVal, 1'b0, t0 + 47, "ideal_b1");
        expect_ev(KVal, 1'b1, t0 + 63, "ideal_b2");
        expect_ev(KVal, 1'b1, t0 + 79, "ideal_b3");
        expect_ev(KEnd, 1'b0, t0 + 95, "ideal_end");
        start_bit();
        man_bit(1'b1, 0);
        man_bit(1'b0, 0);
        man_bit(1'b1, 0);
        man_bit(1'b1, 0);
        seg(1'b0, 40);
        chk("hold_bit_in", 32'(bus.Bit_in), 1);
        chk("idle_link_active", 32'(bus.link_active), 0);

        // Jittered frame: -2 and +2 resync early/late, the final +3 edge is outside the window.
        t0 = cyc + 1;
        expect_ev(KVal, 1'b1, t0 + 29, "jit_b0");
        expect_ev(KVal, 1'b0, t0 + 47, "jit_b1");
        expect_ev(KVal, 1'b1, t0 + 61, "jit_b2");
        expect_ev(KVal, 1'b1, t0 + 77, "jit_b3");
        expect_ev(KEnd, 1'b0, t0 + 93, "jit_end");
        start_bit();
        man_bit(1'b1, -2);
        man_bit(1'b0, 2);
        man_bit(1'b1, -2);
        man_bit(1'b1, 3);
        seg(1'b0, 40);

        // Data 0 then a full high bit (pair 11).
        t0 = cyc + 1;
        expect_ev(KVal, 1'b0, t0 + 31, "viol_b0");
        expect_ev(KErr, 1'b0, t0 + 47, "viol_err");
        start_bit();
        man_bit(1'b0, 0);
        seg(1'b1, 16);
        seg(1'b0, 20);
        chk("viol_link_drop", 32'(bus.link_active), 0);

        // Line stuck high: invalid start bit.
        t0 = cyc + 1;
        expect_ev(KErr, 1'b0, t0 + 15, "bad_start_err");
        seg(1'b1, 40);
        seg(1'b0, 30);
        chk("bad_start_link", 32'(bus.link_active), 0);

        // One-clock glitch: START entered, silent return to HUNT.
        t0 = cyc + 1;
        seg(1'b1, 1);
        seg(1'b0, 4);
        chk("glitch_link_up", 32'(bus.link_active), 1);
        seg(1'b0, 16);
        chk("glitch_link_down", 32'(bus.link_active), 0);
        seg(1'b0, 20);

        // Reset in the middle of bit 2 of a longer frame.
        t0 = cyc + 1;
        expect_ev(KVal, 1'b1, t0 + 31, "rst_frame_b0");
        expect_ev(KVal, 1'b1, t0 + 47, "rst_frame_b1");
        start_bit();
        man_bit(1'b1, 0);
        man_bit(1'b1, 0);
        seg(1'b0, 8);
        chk("pre_rst_link", 32'(bus.link_active), 1);
        chk("pre_rst_bit_in", 32'(bus.Bit_in), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bit_in", 32'(bus.Bit_in), 0);
        chk("mid_rst_valid", 32'(bus.Bit_in_valid), 0);
        chk("mid_rst_link", 32'(bus.link_active), 0);
        chk("mid_rst_frame_end", 32'(bus.frame_end), 0);
        chk("mid_rst_code_err", 32'(bus.code_err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seg(1'b0, 40);
        chk("post_rst_link", 32'(bus.link_active), 0);

        // Fresh frame 0,1 after the reset.
        t0 = cyc + 1;
        expect_ev(KVal, 1'b0, t0 + 31, "fresh_b0");
        expect_ev(KVal, 1'b1, t0 + 47, "fresh_b1");
        expect_ev(KEnd, 1'b0, t0 + 63, "fresh_end");
        start_bit();
        man_bit(1'b0, 0);
        man_bit(1'b1, 0);
        seg(1'b0, 40);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
